// File: rtl/digitizer_gate_sequencer_if.sv
// -----------------------------------------------------------------------------
// digitizer_gate_sequencer_if
//
// Purpose: bundles the per-channel pulse, gate, count and status signals of
// the digitizer gate sequencer into one interface.
//
// Signals (all synchronous to the sequencer clock):
//   x         [NUM_CH]         input pulse train, one bit per channel
//   gate      [NUM_CH]         level-sensitive arm/load gate per channel
//   n_emit    [NUM_CH*CNT_W]   pulses to pass, channel c at [c*CNT_W +: CNT_W]
//   n_skip    [NUM_CH*CNT_W]   pulses to discard first, same packing
//   miss_clr  [1]              clears every missed-pulse counter
//   y         [NUM_CH]         gated pulse output
//   busy      [NUM_CH]         channel is not idle
//   done      [NUM_CH]         one-cycle pulse at the end of an emit window
//   missed    [NUM_CH*MISS_W]  saturating count of pulses seen while idle
//
// Modports: master drives the stimulus side (pulse distribution / control),
// slave is the sequencer itself.
// -----------------------------------------------------------------------------
interface digitizer_gate_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int MISS_W = 16
);
  logic [NUM_CH-1:0]        x;
  logic [NUM_CH-1:0]        gate;
  logic [NUM_CH*CNT_W-1:0]  n_emit;
  logic [NUM_CH*CNT_W-1:0]  n_skip;
  logic                     miss_clr;
  logic [NUM_CH-1:0]        y;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        done;
  logic [NUM_CH*MISS_W-1:0] missed;

  modport master (
    output x, gate, n_emit, n_skip, miss_clr,
    input  y, busy, done, missed
  );

  modport slave (
    input  x, gate, n_emit, n_skip, miss_clr,
    output y, busy, done, missed
  );
endinterface

// File: rtl/digitizer_gate_sequencer.sv
// -----------------------------------------------------------------------------
// digitizer_gate_sequencer
//
// Purpose: NUM_CH independent gate sequencers between the laser pulse-train
// distribution and the digitizer trigger inputs. While a channel's gate is
// high it loads its skip/emit counts; after the gate falls it discards
// n_skip pulses, passes the next n_emit pulses to y, then pulses done and
// returns to idle. Pulses arriving while idle are counted in missed.
//
// Ports:
//   clk    system clock, every state change on the rising edge
//   reset  synchronous, active-high reset
//   bus    digitizer_gate_sequencer_if.slave (x, gate, n_emit, n_skip,
//          miss_clr in; y, busy, done, missed out)
//
// y is combinational from x and registered state (zero latency); busy, done
// and missed are registered.
// -----------------------------------------------------------------------------
module digitizer_gate_sequencer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int MISS_W       = 16,
  parameter int PASS_IN_GATE = 1
) (
  input logic                       clk,
  input logic                       reset,
  digitizer_gate_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SKIP = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

  localparam logic              PASS_BIT = (PASS_IN_GATE != 0);
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  // Per-channel results gathered here, then packed onto the bus in one place.
  logic              y_ch      [NUM_CH];
  logic              busy_ch   [NUM_CH];
  logic              done_ch   [NUM_CH];
  logic [MISS_W-1:0] missed_ch [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             x_c;
      logic             gate_c;
      logic [CNT_W-1:0] n_skip_c;
      logic [CNT_W-1:0] n_emit_c;

      state_t            state_q,  state_d;
      logic [CNT_W-1:0]  skip_q,   skip_d;
      logic [CNT_W-1:0]  emit_q,   emit_d;
      logic [MISS_W-1:0] missed_q, missed_d;
      logic              done_q,   done_d;
      logic              busy_q,   busy_d;

      // State the channel is effectively in this cycle. On the first
      // gate-low cycle LOAD resolves immediately to its exit state, so a
      // pulse arriving on that very cycle is already skipped/emitted/missed.
      state_t            eff_state;
      logic              exit_done;
      logic              y_c;

      assign x_c      = bus.x[gi];
      assign gate_c   = bus.gate[gi];
      assign n_skip_c = bus.n_skip[gi*CNT_W +: CNT_W];
      assign n_emit_c = bus.n_emit[gi*CNT_W +: CNT_W];

      always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        emit_d    = emit_q;
        missed_d  = missed_q;
        done_d    = 1'b0;
        y_c       = 1'b0;
        exit_done = 1'b0;
        eff_state = state_q;

        if (state_q == ST_LOAD) begin
          if (skip_q != CNT_ZERO) begin
            eff_state = ST_SKIP;
          end else if (emit_q != CNT_ZERO) begin
            eff_state = ST_EMIT;
          end else begin
            // Empty window: finishes as soon as the gate falls.
            eff_state = ST_IDLE;
            exit_done = 1'b1;
          end
        end

        if (gate_c) begin
          // Gate wins over any pulse-driven transition and aborts an
          // in-flight window without done. A pulse coinciding with the
          // retrigger of an emitting channel still goes out.
          state_d = ST_LOAD;
          skip_d  = n_skip_c;
          emit_d  = n_emit_c;
          y_c     = x_c & (PASS_BIT | (state_q == ST_EMIT));
        end else begin
          state_d = eff_state;
          done_d  = exit_done;
          case (eff_state)
            ST_IDLE: begin
              if (x_c && (missed_q != MISS_MAX)) begin
                missed_d = missed_q + MISS_ONE;
              end
            end
            ST_SKIP: begin
              if (x_c) begin
                skip_d = skip_q - CNT_ONE;
                // The pulse that exhausts the skip count is swallowed.
                if (skip_q == CNT_ONE) begin
                  if (emit_q != CNT_ZERO) begin
                    state_d = ST_EMIT;
                  end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                  end
                end
              end
            end
            ST_EMIT: begin
              y_c = x_c;
              if (x_c) begin
                emit_d = emit_q - CNT_ONE;
                if (emit_q == CNT_ONE) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end

        if (bus.miss_clr) begin
          missed_d = '0;
        end

        busy_d = (state_d != ST_IDLE);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q  <= ST_IDLE;
          skip_q   <= '0;
          emit_q   <= '0;
          missed_q <= '0;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
        end else begin
          state_q  <= state_d;
          skip_q   <= skip_d;
          emit_q   <= emit_d;
          missed_q <= missed_d;
          done_q   <= done_d;
          busy_q   <= busy_d;
        end
      end

      assign y_ch[gi]      = y_c;
      assign busy_ch[gi]   = busy_q;
      assign done_ch[gi]   = done_q;
      assign missed_ch[gi] = missed_q;
    end
  endgenerate

  always_comb begin
    bus.y      = '0;
    bus.busy   = '0;
    bus.done   = '0;
    bus.missed = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.y[c]                        = y_ch[c];
      bus.busy[c]                     = busy_ch[c];
      bus.done[c]                     = done_ch[c];
      bus.missed[c*MISS_W +: MISS_W]  = missed_ch[c];
    end
  end

endmodule

// File: tb/tb_digitizer_gate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_digitizer_gate_sequencer
//
// Scoreboard bench. The stimulus process drives one cycle at a time, runs a
// window-count reference model (pulse k after the gate fall is emitted when
// n_skip < k <= n_skip + n_emit, and the window ends at k = n_skip + n_emit)
// and pushes the expected outputs. The monitor pops one entry per cycle on
// the falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_digitizer_gate_sequencer;

  localparam int NCH  = 4;
  localparam int CW   = 32;
  localparam int MW   = 16;
  localparam int MMAX = (1 << MW) - 1;

  logic clk;
  logic reset;

  digitizer_gate_sequencer_if #(.NUM_CH(NCH), .CNT_W(CW), .MISS_W(MW)) ifc ();

  digitizer_gate_sequencer #(
    .NUM_CH(NCH), .CNT_W(CW), .MISS_W(MW), .PASS_IN_GATE(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit              chk;
    logic [NCH-1:0]  y;
    logic [NCH-1:0]  busy;
    logic [NCH-1:0]  done;
    logic [NCH*MW-1:0] missed;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit known  = 0;

  // Reference model state, per channel.
  logic [CW-1:0] nskip_v [NCH];
  logic [CW-1:0] nemit_v [NCH];
  bit            m_loaded [NCH];
  bit            m_active [NCH];
  longint        m_s [NCH];
  longint        m_e [NCH];
  longint        m_k [NCH];
  int            m_missed [NCH];
  bit            m_done [NCH];
  bit            m_busy [NCH];
  int            y_seen [NCH];
  int            done_seen [NCH];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", nm, cycle, got, exp);
    end
  endtask

  // One clock cycle of stimulus plus the model's view of it.
  task automatic cyc(input logic [NCH-1:0] g, input logic [NCH-1:0] xx,
                     input logic mc, input logic rs);
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    reset        = rs;
    ifc.gate     = g;
    ifc.x        = xx;
    ifc.miss_clr = mc;
    for (int c = 0; c < NCH; c++) begin
      ifc.n_skip[c*CW +: CW] = nskip_v[c];
      ifc.n_emit[c*CW +: CW] = nemit_v[c];
    end

    e = '0;
    e.chk = known;
    for (int c = 0; c < NCH; c++) begin
      e.busy[c] = m_busy[c];
      e.done[c] = m_done[c];
      e.missed[c*MW +: MW] = MW'(m_missed[c]);
    end

    for (int c = 0; c < NCH; c++) begin
      bit yb = 0;
      bit consumed = 0;
      bit fin = 0;
      if (g[c]) begin
        yb = xx[c];
        m_loaded[c] = 1;
        m_active[c] = 0;
        m_s[c] = longint'(nskip_v[c]);
        m_e[c] = longint'(nemit_v[c]);
      end else begin
        if (m_loaded[c]) begin
          m_loaded[c] = 0;
          if (m_s[c] + m_e[c] == 0) fin = 1;
          else begin
            m_active[c] = 1;
            m_k[c] = 0;
          end
        end
        if (m_active[c] && xx[c]) begin
          consumed = 1;
          m_k[c]++;
          yb = (m_k[c] > m_s[c]) && (m_k[c] <= m_s[c] + m_e[c]);
          if (m_k[c] == m_s[c] + m_e[c]) begin
            m_active[c] = 0;
            fin = 1;
          end
        end
        if (xx[c] && !consumed && m_missed[c] < MMAX) m_missed[c]++;
      end
      if (mc) m_missed[c] = 0;
      m_done[c] = fin;
      m_busy[c] = m_loaded[c] || m_active[c];
      if (rs) begin
        m_loaded[c] = 0;
        m_active[c] = 0;
        m_missed[c] = 0;
        m_done[c]   = 0;
        m_busy[c]   = 0;
      end
      e.y[c] = yb;
    end
    sb.push_back(e);
    if (rs) known = 1;
  endtask

  // Monitor: one expected entry per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          chk("y",      64'(ifc.y),      64'(e.y));
          chk("busy",   64'(ifc.busy),   64'(e.busy));
          chk("done",   64'(ifc.done),   64'(e.done));
          chk("missed", 64'(ifc.missed), 64'(e.missed));
          for (int c = 0; c < NCH; c++) begin
            if (ifc.y[c] === 1'b1) y_seen[c]++;
            if (ifc.done[c] === 1'b1) done_seen[c]++;
          end
        end
      end
    end
  end

  function automatic logic [CW-1:0] rnd_cnt();
    if ($urandom_range(0, 15) == 0) return '1;
    return CW'($urandom_range(0, 4));
  endfunction

  task automatic note(input string nm);
    $display("INFO %s cycle %0d y_seen %0d/%0d/%0d/%0d done_seen %0d/%0d/%0d/%0d",
             nm, cycle, y_seen[0], y_seen[1], y_seen[2], y_seen[3],
             done_seen[0], done_seen[1], done_seen[2], done_seen[3]);
  endtask

  initial begin
    logic [NCH-1:0] g;
    logic [NCH-1:0] xr;
    reset = 1'b1;
    ifc.gate = '0;
    ifc.x = '0;
    ifc.miss_clr = 1'b0;
    ifc.n_skip = '0;
    ifc.n_emit = '0;
    for (int c = 0; c < NCH; c++) begin
      nskip_v[c] = '0;
      nemit_v[c] = '0;
      m_loaded[c] = 0; m_active[c] = 0; m_missed[c] = 0;
      m_done[c] = 0; m_busy[c] = 0; m_s[c] = 0; m_e[c] = 0; m_k[c] = 0;
      y_seen[c] = 0; done_seen[c] = 0;
    end

    // Reset.
    cyc('0, '0, 1'b0, 1'b1);
    cyc('0, '0, 1'b0, 1'b1);
    cyc('0, '0, 1'b0, 1'b0);
    note("reset");

    // Skip 2, emit 3, eight single-cycle pulses after the gate.
    nskip_v[0] = 2; nemit_v[0] = 3;
    repeat (4) cyc(4'b0001, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc('0, 4'b0001, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
    end
    note("skip2_emit3");

    // Empty window, then idle pulses counted as missed.
    nskip_v[0] = 0; nemit_v[0] = 0;
    repeat (2) cyc(4'b0001, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc('0, 4'b0001, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
    end
    note("empty_window");

    // In-gate pulses pass and do not consume the emit count.
    nskip_v[0] = 0; nemit_v[0] = 1;
    cyc(4'b0001, '0, 1'b0, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, '0, 1'b0, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc('0, '0, 1'b0, 1'b0);
      cyc('0, 4'b0001, 1'b0, 1'b0);
    end
    cyc('0, '0, 1'b0, 1'b0);
    note("pass_in_gate");

    // Retrigger mid-emit with a new count.
    nskip_v[0] = 0; nemit_v[0] = 5;
    repeat (2) cyc(4'b0001, '0, 1'b0, 1'b0);
    repeat (2) begin
      cyc('0, 4'b0001, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
    end
    nemit_v[0] = 2;
    repeat (2) cyc(4'b0001, '0, 1'b0, 1'b0);
    repeat (4) begin
      cyc('0, 4'b0001, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);
    end
    note("retrigger");

    // Final emit pulse coinciding with a retrigger.
    nskip_v[1] = 1; nemit_v[1] = 1;
    cyc(4'b0010, '0, 1'b0, 1'b0);
    cyc('0, 4'b0010, 1'b0, 1'b0);
    cyc(4'b0010, 4'b0010, 1'b0, 1'b0);
    nskip_v[1] = 0; nemit_v[1] = 0;
    cyc(4'b0010, '0, 1'b0, 1'b0);
    repeat (3) cyc('0, '0, 1'b0, 1'b0);
    note("emit_vs_retrigger");

    // Randomised, staggered multi-channel traffic.
    g = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (g[c]) g[c] = ($urandom_range(0, 2) != 0);
        else      g[c] = ($urandom_range(0, 24) == 0);
        nskip_v[c] = rnd_cnt();
        nemit_v[c] = rnd_cnt();
        xr[c] = ($urandom_range(0, 2) == 0);
      end
      cyc(g, xr, ($urandom_range(0, 199) == 0), 1'b0);
    end
    cyc('0, '0, 1'b0, 1'b0);
    note("random");

    // Reset in the middle of an emit window.
    nskip_v[0] = 0; nemit_v[0] = 10;
    cyc(4'b0001, '0, 1'b0, 1'b0);
    repeat (3) cyc('0, 4'b0001, 1'b0, 1'b0);
    cyc('0, 4'b0001, 1'b0, 1'b1);
    repeat (2) cyc('0, 4'b0001, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    note("reset_mid_emit");

    // Missed-counter saturation and clear priority.
    cyc('0, '0, 1'b1, 1'b0);
    repeat (MMAX - 1) cyc('0, 4'hF, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    chk("missed_at_fffe", 64'(ifc.missed), 64'h fffe_fffe_fffe_fffe);
    repeat (3) cyc('0, 4'hF, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    chk("missed_saturated", 64'(ifc.missed), 64'h ffff_ffff_ffff_ffff);
    cyc('0, 4'hF, 1'b1, 1'b0);
    cyc('0, '0, 1'b0, 1'b0);
    chk("missed_cleared", 64'(ifc.missed), 64'h0);
    note("saturation");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain cycle %0d got %0d entries expected 0", cycle, sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
